layer0_input_stager: RTL and testbench
======================================

LAYER0_INPUT_STAGER -- requirements
Module: layer0_input_stager

Interface
REQ-001 SHALL have parameter FEAT_W, default 2, bits per quantised input feature.
REQ-002 SHALL have parameter NUM_FEAT, default 16, features per frame; legal range 2..64.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port s_data  input  FEAT_W  one feature per beat, in arrival order.
REQ-006 SHALL have port s_valid  input  1  upstream beat valid.
REQ-007 SHALL have port s_last  input  1  marks the final beat of a frame.
REQ-008 SHALL have port s_ready  output  1  stager accepts a beat this cycle.
REQ-009 SHALL have port m_data  output  FEAT_W*NUM_FEAT  assembled frame, parallel input vector for the layer0 neuron LUTs.
REQ-010 SHALL have port m_valid  output  1  m_data holds a complete frame.
REQ-011 SHALL have port m_ready  input  1  layer0 consumer accepts the frame.
REQ-012 SHALL have port err_short  output  1  one-cycle pulse: frame truncated by early s_last.
REQ-013 SHALL have port err_long  output  1  one-cycle pulse: frame exceeded NUM_FEAT beats.

Function
REQ-014 SHALL count an input beat only when s_valid && s_ready, and an output transfer only when m_valid && m_ready.
REQ-015 SHALL write the beat with index k (0-based within the frame) to assembly bits [k*FEAT_W +: FEAT_W]; the beat counter is ceil(log2(NUM_FEAT)) bits wide and never exceeds NUM_FEAT-1.
REQ-016 SHALL hold two registers: an assembly register and an output register (m_data); the assembly register moves to the output register as a whole, never partially.
REQ-017 SHALL implement states FILL, HOLD and DROP.
REQ-018 FILL: s_ready=1; on beat index NUM_FEAT-1, go to HOLD with counter reset to 0.
REQ-019 FILL: s_last on a beat with index < NUM_FEAT-1 SHALL discard the partial frame, reset the counter to 0, pulse err_short the next cycle and stay in FILL.
REQ-020 FILL: a beat with index NUM_FEAT-1 and s_last=0 SHALL complete the frame normally, pulse err_long the next cycle, and go to DROP instead of HOLD while still handing the frame to the transfer logic.
REQ-021 DROP: s_ready=1, beats are discarded, and the beat carrying s_last returns the block to HOLD if the completed frame has not yet transferred, otherwise to FILL.
REQ-022 HOLD: transfer SHALL occur in any cycle where (!m_valid || m_ready); in that cycle s_ready=1 and a beat accepted in the same cycle is written as index 0 of the next frame, and the state returns to FILL.
REQ-023 HOLD without transfer: s_ready=0.
REQ-024 SHALL assert m_valid in the cycle after a transfer and keep m_data stable while m_valid && !m_ready.
REQ-025 SHALL deassert m_valid after an output handshake unless a new transfer occurs in that same cycle, in which case m_valid stays 1 with the new frame.
REQ-026 Latency: final-beat handshake in cycle t with the output register free SHALL give m_valid=1 in cycle t+2.
REQ-027 SHALL sustain one beat per cycle indefinitely when m_ready is held 1, with no bubbles on s_ready.
REQ-028 err_short and err_long SHALL be registered, never both high, and 0 in all other cycles.

Reset
REQ-029 While rst=1: state=FILL, counter=0, m_valid=0, err_short=0, err_long=0, and s_ready=0 during reset.
REQ-030 m_data and the assembly register SHALL reset to all zeros.
REQ-031 Reset asserted mid-frame or with m_valid=1 SHALL discard all buffered data; first cycle after release: s_ready=1, m_valid=0.

Verification (bench with NUM_FEAT=4, FEAT_W=2)
REQ-032 Beats 1,2,3,0 with s_last on the 4th, m_ready=1 -> m_valid two cycles after the last beat, m_data=8'b00111001.
REQ-033 Three back-to-back frames, m_ready=1 -> s_ready constantly 1, three m_valid frames in order, no error pulses.
REQ-034 m_ready=0 after frame A, then frame B fully sent -> s_ready=0 after B's last beat; m_data=A held; one m_ready pulse -> next cycle m_data=B, s_ready=1.
REQ-035 s_last on beat index 1 -> err_short=1 for one cycle, no m_valid; next 4-beat frame delivered intact.
REQ-036 6 beats, s_last on the 6th -> err_long=1 once, m_data holds the first 4 beats, beats 5-6 dropped.
REQ-037 rst pulsed after 2 beats of a frame -> m_valid=0, counter=0; the following full frame is delivered correctly.

Source files
------------

// File: rtl/layer0_input_stager_if.sv
// Stream-in / frame-out bundle for the layer0 input stager.
// slave = stager side, master = producer/consumer side driving the stager.
interface layer0_input_stager_if #(
  parameter int FEAT_W   = 2,
  parameter int NUM_FEAT = 16
);
  logic [FEAT_W-1:0]          s_data;
  logic                       s_valid;
  logic                       s_last;
  logic                       s_ready;
  logic [FEAT_W*NUM_FEAT-1:0] m_data;
  logic                       m_valid;
  logic                       m_ready;
  logic                       err_short;
  logic                       err_long;
  logic [1:0]                 dbg_state;

  // Both sides use valid/ready: a beat or frame moves only in a cycle where
  // valid && ready; the source holds data stable while valid && !ready.
  modport slave (
    input  s_data, s_valid, s_last, m_ready,
    output s_ready, m_data, m_valid, err_short, err_long, dbg_state
  );

  modport master (
    output s_data, s_valid, s_last, m_ready,
    input  s_ready, m_data, m_valid, err_short, err_long, dbg_state
  );
endinterface

// File: rtl/layer0_input_stager.sv
// Serial-to-parallel stager: packs FEAT_W-bit feature beats into one
// NUM_FEAT-wide frame and hands it to the layer0 LUT array as a whole.
module layer0_input_stager #(
  parameter int FEAT_W   = 2,
  parameter int NUM_FEAT = 16
) (
  input logic clk,
  input logic rst,
  layer0_input_stager_if.slave bus
);
  localparam int CW = $clog2(NUM_FEAT);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_FEAT - 1);

  localparam logic [1:0] FILL = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]                 r_state;
  logic [CW-1:0]              r_cnt;
  logic [FEAT_W*NUM_FEAT-1:0] r_asm;
  logic                       r_full;
  logic [FEAT_W*NUM_FEAT-1:0] r_mdata;
  logic                       r_mvalid;
  logic                       r_err_short;
  logic                       r_err_long;

  logic w_xfer;
  logic w_sready;
  logic w_beat;
  logic w_last_idx;

  // r_full marks a complete frame in the assembly register; it can still be
  // pending while DROP swallows the tail of an over-long frame.
  always_comb begin
    w_xfer     = r_full && (!r_mvalid || bus.m_ready);
    w_sready   = !rst && ((r_state != HOLD) || w_xfer);
    w_beat     = bus.s_valid && w_sready;
    w_last_idx = (r_cnt == LAST_IDX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= FILL;
      r_cnt       <= '0;
      r_asm       <= '0;
      r_full      <= 1'b0;
      r_mdata     <= '0;
      r_mvalid    <= 1'b0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
    end else begin
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;

      if (w_xfer) begin
        r_mdata  <= r_asm;
        r_mvalid <= 1'b1;
        r_full   <= 1'b0;
      end else if (bus.m_ready) begin
        r_mvalid <= 1'b0;
      end

      case (r_state)
        FILL: begin
          if (w_beat) begin
            for (int k = 0; k < NUM_FEAT; k++) begin
              if (r_cnt == CW'(k)) r_asm[k*FEAT_W +: FEAT_W] <= bus.s_data;
            end
            if (w_last_idx) begin
              r_cnt      <= '0;
              r_full     <= 1'b1;
              r_state    <= bus.s_last ? HOLD : DROP;
              r_err_long <= !bus.s_last;
            end else if (bus.s_last) begin
              r_cnt       <= '0;
              r_err_short <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        HOLD: begin
          // The beat accepted alongside the transfer opens the next frame.
          if (w_xfer) begin
            r_state <= FILL;
            if (w_beat) begin
              r_asm[FEAT_W-1:0] <= bus.s_data;
              if (bus.s_last) r_err_short <= 1'b1;
              else            r_cnt       <= CW'(1);
            end
          end
        end
        DROP: begin
          if (w_beat && bus.s_last) r_state <= (r_full && !w_xfer) ? HOLD : FILL;
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign bus.s_ready   = w_sready;
  assign bus.m_data    = r_mdata;
  assign bus.m_valid   = r_mvalid;
  assign bus.err_short = r_err_short;
  assign bus.err_long  = r_err_long;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_layer0_input_stager.sv
// Directed table-driven bench for layer0_input_stager with NUM_FEAT=4, FEAT_W=2.
module tb_layer0_input_stager;
  localparam int FEAT_W   = 2;
  localparam int NUM_FEAT = 4;
  localparam int W        = FEAT_W * NUM_FEAT;

  typedef struct {
    logic [1:0]   d;
    logic         v;
    logic         l;
    logic         mr;
    logic         sr;
    logic         mv;
    logic [W-1:0] md;
    logic         es;
    logic         el;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   step_no = 0;
  logic [W-1:0] exp_q[$];
  vec_t vecs[$];

  layer0_input_stager_if #(.FEAT_W(FEAT_W), .NUM_FEAT(NUM_FEAT)) bus ();

  layer0_input_stager #(.FEAT_W(FEAT_W), .NUM_FEAT(NUM_FEAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic [1:0] d, logic v, logic l, logic mr,
                              logic sr, logic mv, logic [W-1:0] md,
                              logic es, logic el);
    vec_t r;
    r.d = d; r.v = v; r.l = l; r.mr = mr;
    r.sr = sr; r.mv = mv; r.md = md; r.es = es; r.el = el;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a falling edge: drive one cycle of inputs, check, advance.
  task automatic step(input vec_t v);
    string tag;
    tag = $sformatf("step%0d", step_no);
    bus.s_data  = v.d;
    bus.s_valid = v.v;
    bus.s_last  = v.l;
    bus.m_ready = v.mr;
    #1;
    chk({tag, " s_ready"},   32'(bus.s_ready),   32'(v.sr));
    chk({tag, " m_valid"},   32'(bus.m_valid),   32'(v.mv));
    chk({tag, " err_short"}, 32'(bus.err_short), 32'(v.es));
    chk({tag, " err_long"},  32'(bus.err_long),  32'(v.el));
    if (v.mv) chk({tag, " m_data"}, 32'(bus.m_data), 32'(v.md));
    if (bus.m_valid && v.mr) begin
      if (exp_q.size() == 0) begin
        chk({tag, " unexpected frame"}, 32'(bus.m_data), 32'hFFFF_FFFF);
      end else begin
        chk({tag, " scoreboard frame"}, 32'(bus.m_data), 32'(exp_q.pop_front()));
      end
    end
    step_no++;
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " s_ready"},   32'(bus.s_ready),   32'd0);
    chk({tag, " m_valid"},   32'(bus.m_valid),   32'd0);
    chk({tag, " m_data"},    32'(bus.m_data),    32'd0);
    chk({tag, " err_short"}, 32'(bus.err_short), 32'd0);
    chk({tag, " err_long"},  32'(bus.err_long),  32'd0);
    chk({tag, " state"},     32'(bus.dbg_state), 32'd0);
  endtask

  initial begin
    bus.s_data  = '0;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;

    // Single frame 1,2,3,0 -> 8'h39 two cycles after the last beat
    vecs.push_back(mk(2'd1,1,0,1, 1,0,8'h00,0,0));
    vecs.push_back(mk(2'd2,1,0,1, 1,0,8'h00,0,0));
    vecs.push_back(mk(2'd3,1,0,1, 1,0,8'h00,0,0));
    vecs.push_back(mk(2'd0,1,1,1, 1,0,8'h00,0,0));
    vecs.push_back(mk(2'd0,0,0,1, 1,0,8'h00,0,0));
    vecs.push_back(mk(2'd0,0,0,1, 1,1,8'h39,0,0));
    vecs.push_back(mk(2'd0,0,0,1, 1,0,8'h00,0,0));
    // Three back-to-back frames: FF, E4, D2
    vecs.push_back(mk(2'd3,1,0,1, 1,0,8'h00,0,0));
    vecs.push_back(mk(2'd3,1,0,1, 1,0,8'h00,0,0));
    vecs.push_back(mk(2'd3,1,0,1, 1,0,8'h00,0,0));
    vecs.push_back(mk(2'd3,1,1,1, 1,0,8'h00,0,0));
    vecs.push_back(mk(2'd0,1,0,1, 1,0,8'h00,0,0));
    vecs.push_back(mk(2'd1,1,0,1, 1,1,8'hFF,0,0));
    vecs.push_back(mk(2'd2,1,0,1, 1,0,8'h00,0,0));
    vecs.push_back(mk(2'd3,1,1,1, 1,0,8'h00,0,0));
    vecs.push_back(mk(2'd2,1,0,1, 1,0,8'h00,0,0));
    vecs.push_back(mk(2'd0,1,0,1, 1,1,8'hE4,0,0));
    vecs.push_back(mk(2'd1,1,0,1, 1,0,8'h00,0,0));
    vecs.push_back(mk(2'd3,1,1,1, 1,0,8'h00,0,0));
    vecs.push_back(mk(2'd0,0,0,1, 1,0,8'h00,0,0));
    vecs.push_back(mk(2'd0,0,0,1, 1,1,8'hD2,0,0));
    vecs.push_back(mk(2'd0,0,0,1, 1,0,8'h00,0,0));
    // Back-pressure: frame A=55 waits, frame B=AA fills, s_ready drops
    vecs.push_back(mk(2'd1,1,0,0, 1,0,8'h00,0,0));
    vecs.push_back(mk(2'd1,1,0,0, 1,0,8'h00,0,0));
    vecs.push_back(mk(2'd1,1,0,0, 1,0,8'h00,0,0));
    vecs.push_back(mk(2'd1,1,1,0, 1,0,8'h00,0,0));
    vecs.push_back(mk(2'd2,1,0,0, 1,0,8'h00,0,0));
    vecs.push_back(mk(2'd2,1,0,0, 1,1,8'h55,0,0));
    vecs.push_back(mk(2'd2,1,0,0, 1,1,8'h55,0,0));
    vecs.push_back(mk(2'd2,1,1,0, 1,1,8'h55,0,0));
    vecs.push_back(mk(2'd0,0,0,0, 0,1,8'h55,0,0));
    vecs.push_back(mk(2'd0,0,0,1, 1,1,8'h55,0,0));
    vecs.push_back(mk(2'd0,0,0,0, 1,1,8'hAA,0,0));
    vecs.push_back(mk(2'd0,0,0,1, 1,1,8'hAA,0,0));
    vecs.push_back(mk(2'd0,0,0,1, 1,0,8'h00,0,0));
    // Short frame (s_last on index 1), then intact frame B1
    vecs.push_back(mk(2'd3,1,0,1, 1,0,8'h00,0,0));
    vecs.push_back(mk(2'd2,1,1,1, 1,0,8'h00,0,0));
    vecs.push_back(mk(2'd1,1,0,1, 1,0,8'h00,1,0));
    vecs.push_back(mk(2'd0,1,0,1, 1,0,8'h00,0,0));
    vecs.push_back(mk(2'd3,1,0,1, 1,0,8'h00,0,0));
    vecs.push_back(mk(2'd2,1,1,1, 1,0,8'h00,0,0));
    vecs.push_back(mk(2'd0,0,0,1, 1,0,8'h00,0,0));
    vecs.push_back(mk(2'd0,0,0,1, 1,1,8'hB1,0,0));
    vecs.push_back(mk(2'd0,0,0,1, 1,0,8'h00,0,0));
    // Long frame: 6 beats, first 4 kept (E4), beats 5-6 dropped
    vecs.push_back(mk(2'd0,1,0,1, 1,0,8'h00,0,0));
    vecs.push_back(mk(2'd1,1,0,1, 1,0,8'h00,0,0));
    vecs.push_back(mk(2'd2,1,0,1, 1,0,8'h00,0,0));
    vecs.push_back(mk(2'd3,1,0,1, 1,0,8'h00,0,0));
    vecs.push_back(mk(2'd1,1,0,1, 1,0,8'h00,0,1));
    vecs.push_back(mk(2'd2,1,1,1, 1,1,8'hE4,0,0));
    vecs.push_back(mk(2'd0,0,0,1, 1,0,8'h00,0,0));

    exp_q.push_back(8'h39);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hE4);
    exp_q.push_back(8'hD2);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'hB1);
    exp_q.push_back(8'hE4);

    // Reset state
    @(negedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Reset while a frame sits in m_data (unconsumed) and another is half built
    step(mk(2'd3,1,0,0, 1,0,8'h00,0,0));
    step(mk(2'd0,1,0,0, 1,0,8'h00,0,0));
    step(mk(2'd0,1,0,0, 1,0,8'h00,0,0));
    step(mk(2'd0,1,1,0, 1,0,8'h00,0,0));
    step(mk(2'd0,0,0,0, 1,0,8'h00,0,0));
    step(mk(2'd1,1,0,0, 1,1,8'h03,0,0));
    step(mk(2'd2,1,0,0, 1,1,8'h03,0,0));
    bus.s_data  = 2'd3;
    bus.s_valid = 1'b1;
    rst = 1'b1;
    #1;
    check_reset_state("midreset");
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(8'h39);
    step(mk(2'd1,1,0,1, 1,0,8'h00,0,0));
    step(mk(2'd2,1,0,1, 1,0,8'h00,0,0));
    step(mk(2'd3,1,0,1, 1,0,8'h00,0,0));
    step(mk(2'd0,1,1,1, 1,0,8'h00,0,0));
    step(mk(2'd0,0,0,1, 1,0,8'h00,0,0));
    step(mk(2'd0,0,0,1, 1,1,8'h39,0,0));
    step(mk(2'd0,0,0,1, 1,0,8'h00,0,0));

    chk("frames left in queue", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
